// File: rtl/wdt_timer_core.sv
// Watchdog counter driven by decoded register writes; optional tick prescaler via WDT_PRESCALE_EN.
// Writes land on the next ACLK edge with no backpressure; interrupt rises (N+1) ticks after enable.
module wdt_timer_core #(
   parameter int          ADDR_W    = 32,
   parameter logic [31:0] TOCNT_RST = 32'hFFFF_FFFF,
   parameter int          PRESCALE  = 16
) (
   input  logic              ACLK,
   input  logic              ARESETn,
   input  logic              wr_en,
   input  logic [ADDR_W-1:0] wr_addr,
   input  logic [31:0]       wr_data,
   input  logic [3:0]        wr_strb,
   output logic              wden_o,
   output logic [31:0]       cnt_o,
   output logic              WDT_interrupt
);

   typedef enum logic [1:0] {S_IDLE, S_COUNT, S_TIMEOUT} state_e;

   state_e      state;
   logic        wden_q, wden_d;
   logic [31:0] wtocnt_q, wtocnt_d;
   logic [31:0] cnt_q, cnt_d;
   logic        int_q, int_d;
   logic        clr;
   logic        tick;
   logic [11:0] off;
   logic        unused_addr;

   assign off         = wr_addr[11:0];
   assign unused_addr = ^wr_addr[ADDR_W-1:12];

   always_comb begin
      state = S_IDLE;
      if (wden_q) state = int_q ? S_TIMEOUT : S_COUNT;
   end

`ifdef WDT_PRESCALE_EN
   localparam int PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
   logic [PW-1:0] pre_q, pre_d;

   assign tick = (pre_q == PW'(PRESCALE - 1));

   always_comb begin
      pre_d = pre_q;
      if (clr)                   pre_d = '0;
      else if (state == S_COUNT) pre_d = tick ? '0 : pre_q + 1'b1;
   end

   always_ff @(posedge ACLK or negedge ARESETn) begin
      if (!ARESETn) pre_q <= '0;
      else          pre_q <= pre_d;
   end
`else
   localparam int UNUSED_PRESCALE = PRESCALE;
   assign tick = 1'b1;
`endif

   always_comb begin
      wden_d   = wden_q;
      wtocnt_d = wtocnt_q;
      cnt_d    = cnt_q;
      int_d    = int_q;
      clr      = 1'b0;
      if (wr_en) begin
         case (off)
            12'h100: begin
               if (wr_strb[0]) wden_d = wr_data[0];
               clr = 1'b1;
            end
            12'h200: if (wr_strb[0] && wr_data[0] && wden_q) clr = 1'b1;
            12'h300: begin
               for (int b = 0; b < 4; b++)
                  if (wr_strb[b]) wtocnt_d[8*b +: 8] = wr_data[8*b +: 8];
               clr = 1'b1;
            end
            default: ;
         endcase
      end
      // A clear in the same cycle as a timeout tick wins over the interrupt set.
      if (clr) begin
         cnt_d = '0;
         int_d = 1'b0;
      end else if (state == S_COUNT && tick) begin
         if (cnt_q == wtocnt_q) int_d = 1'b1;
         else                   cnt_d = cnt_q + 32'd1;
      end
   end

   always_ff @(posedge ACLK or negedge ARESETn) begin
      if (!ARESETn) begin
         wden_q   <= 1'b0;
         wtocnt_q <= TOCNT_RST;
         cnt_q    <= '0;
         int_q    <= 1'b0;
      end else begin
         wden_q   <= wden_d;
         wtocnt_q <= wtocnt_d;
         cnt_q    <= cnt_d;
         int_q    <= int_d;
      end
   end

   assign wden_o        = wden_q;
   assign cnt_o         = cnt_q;
   assign WDT_interrupt = int_q;

endmodule

// File: tb/tb_wdt_timer_core.sv
// Bench for wdt_timer_core: elapsed-time reference model, per-cycle compare, directed and random writes.
module tb_wdt_timer_core;

`ifdef WDT_PRESCALE_EN
   localparam int P_EFF = 4;
`else
   localparam int P_EFF = 1;
`endif

   logic        ACLK = 1'b0;
   logic        ARESETn = 1'b1;
   logic        wr_en = 1'b0;
   logic [31:0] wr_addr = '0;
   logic [31:0] wr_data = '0;
   logic [3:0]  wr_strb = '0;
   logic        wden_o;
   logic [31:0] cnt_o;
   logic        WDT_interrupt;

   int vectors = 0;
   int errors  = 0;
   bit chk_en  = 1'b0;

   wdt_timer_core #(.ADDR_W(32), .TOCNT_RST(32'hFFFF_FFFF), .PRESCALE(4)) dut (
      .ACLK(ACLK), .ARESETn(ARESETn), .wr_en(wr_en), .wr_addr(wr_addr),
      .wr_data(wr_data), .wr_strb(wr_strb), .wden_o(wden_o), .cnt_o(cnt_o),
      .WDT_interrupt(WDT_interrupt));

   always #5 ACLK = ~ACLK;

   // Model: enable flag, timeout value, and core cycles elapsed since the last clear while enabled.
   bit          m_wden;
   logic [31:0] m_to;
   longint      m_el;

   always @(posedge ACLK or negedge ARESETn) begin
      if (!ARESETn) begin
         m_wden = 1'b0;
         m_to   = 32'hFFFF_FFFF;
         m_el   = 0;
      end else begin
         bit          clr;
         bit          old_en;
         logic [31:0] mask;
         clr    = 1'b0;
         old_en = m_wden;
         mask   = {{8{wr_strb[3]}}, {8{wr_strb[2]}}, {8{wr_strb[1]}}, {8{wr_strb[0]}}};
         if (wr_en) begin
            if (wr_addr[11:0] == 12'h100) begin
               if (wr_strb[0]) m_wden = wr_data[0];
               clr = 1'b1;
            end else if (wr_addr[11:0] == 12'h200) begin
               if (wr_strb[0] && wr_data[0] && old_en) clr = 1'b1;
            end else if (wr_addr[11:0] == 12'h300) begin
               m_to = (m_to & ~mask) | (wr_data & mask);
               clr  = 1'b1;
            end
         end
         if (clr)                            m_el = 0;
         else if (old_en && m_el < 64'd1 << 40) m_el = m_el + 1;
      end
   end

   function automatic logic [31:0] exp_cnt();
      longint ticks = m_el / P_EFF;
      longint to    = longint'({32'd0, m_to});
      return (ticks > to) ? m_to : ticks[31:0];
   endfunction

   function automatic logic exp_int();
      longint ticks = m_el / P_EFF;
      return m_wden && (ticks > longint'({32'd0, m_to}));
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      vectors++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
      end
   endtask

   always @(negedge ACLK) begin
      if (chk_en) begin
         chk("model_wden", {31'd0, wden_o}, {31'd0, m_wden});
         chk("model_cnt", cnt_o, exp_cnt());
         chk("model_int", {31'd0, WDT_interrupt}, {31'd0, exp_int()});
      end
   end

   task automatic cyc(input int n);
      repeat (n) begin
         @(posedge ACLK);
         #1;
      end
   endtask

   task automatic wr(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s);
      wr_en = 1'b1; wr_addr = a; wr_data = d; wr_strb = s;
      @(posedge ACLK);
      #1;
      wr_en = 1'b0;
   endtask

   initial begin
      #1_000_000;
      $display("FAIL timeout: simulation exceeded time budget");
      $fatal(1, "time budget exhausted");
   end

   initial begin
      #2 ARESETn = 1'b0;
      chk_en = 1'b1;
      #20 ARESETn = 1'b1;
      @(posedge ACLK); #1;

      cyc(100);
      chk("idle_wden", {31'd0, wden_o}, 32'd0);
      chk("idle_cnt", cnt_o, 32'd0);
      chk("idle_int", {31'd0, WDT_interrupt}, 32'd0);

      // N=10: count to 10, interrupt one tick later, then freeze.
      wr(32'h300, 32'd10, 4'hF);
      wr(32'h100, 32'd1, 4'h1);
      chk("en_cnt0", cnt_o, 32'd0);
      cyc(10 * P_EFF);
      chk("cnt_at_N", cnt_o, 32'd10);
      chk("no_int_at_N", {31'd0, WDT_interrupt}, 32'd0);
      cyc(P_EFF);
      chk("int_at_N1", {31'd0, WDT_interrupt}, 32'd1);
      cyc(9);
      chk("frozen_cnt", cnt_o, 32'd10);
      chk("held_int", {31'd0, WDT_interrupt}, 32'd1);

      wr(32'h200, 32'd1, 4'h1);
      chk("kick_int", {31'd0, WDT_interrupt}, 32'd0);
      chk("kick_cnt", cnt_o, 32'd0);
      cyc(P_EFF);
      chk("restart_cnt", cnt_o, 32'd1);

      for (int i = 0; i < 25; i++) begin
         cyc(7);
         wr(32'h200, 32'd1, 4'h1);
         chk("periodic_kick_cnt", cnt_o, 32'd0);
      end
      chk("periodic_kick_int", {31'd0, WDT_interrupt}, 32'd0);

      wr(32'h100, 32'd0, 4'h1);
      chk("dis_wden", {31'd0, wden_o}, 32'd0);
      cyc(5);
      chk("dis_cnt", cnt_o, 32'd0);
      wr(32'h200, 32'd1, 4'h1);
      chk("dis_kick_wden", {31'd0, wden_o}, 32'd0);
      cyc(3);

      // wtocnt=0 interrupts one tick after enable.
      wr(32'h300, 32'd0, 4'hF);
      wr(32'h100, 32'd1, 4'h1);
      chk("n0_int_E", {31'd0, WDT_interrupt}, 32'd0);
      cyc(P_EFF);
      chk("n0_int_E1", {31'd0, WDT_interrupt}, 32'd1);

      wr(32'h300, 32'd3, 4'hF);
      cyc(4 * P_EFF - 1);
      chk("n3_before", {31'd0, WDT_interrupt}, 32'd0);
      cyc(1);
      chk("n3_int", {31'd0, WDT_interrupt}, 32'd1);

      // Byte strobes: only enabled lanes update the timeout.
      wr(32'h300, 32'hFFFF_FF04, 4'hF);
      wr(32'h300, 32'h0000_0000, 4'b1110);
      cyc(4 * P_EFF);
      chk("strb_cnt4", cnt_o, 32'd4);
      cyc(P_EFF);
      chk("strb_int4", {31'd0, WDT_interrupt}, 32'd1);
      wr(32'h300, 32'h0000_AB00, 4'b0010);
      cyc(20 * P_EFF);
      chk("byte1_cnt", cnt_o, 32'd20);
      chk("byte1_noint", {31'd0, WDT_interrupt}, 32'd0);
      wr(32'h300, 32'h0000_0000, 4'b0010);
      cyc(5 * P_EFF);
      chk("byte0_kept", {31'd0, WDT_interrupt}, 32'd1);

      wr(32'h300, 32'd10, 4'hF);
      cyc(P_EFF - 1);
      wr(32'h104, 32'd0, 4'hF);
      chk("unmapped_cnt", cnt_o, 32'd1);
      chk("unmapped_wden", {31'd0, wden_o}, 32'd1);
      cyc(P_EFF);
      wr(32'hABCD_0200, 32'd1, 4'h1);
      chk("hi_addr_kick", cnt_o, 32'd0);

      wr(32'h300, 32'd10, 4'hF);
      cyc(5 * P_EFF);
      chk("pre_rst_cnt", cnt_o, 32'd5);
      #3 ARESETn = 1'b0;
      #1;
      chk("rst_cnt", cnt_o, 32'd0);
      chk("rst_wden", {31'd0, wden_o}, 32'd0);
      chk("rst_int", {31'd0, WDT_interrupt}, 32'd0);
      #2 ARESETn = 1'b1;
      @(posedge ACLK); #1;
      chk("post_rst_cnt", cnt_o, 32'd0);

      for (int i = 0; i < 2500; i++) begin
         int sel;
         sel     = int'($urandom % 8);
         wr_en   = ($urandom % 3) == 0;
         wr_strb = ($urandom % 2) ? 4'hF : 4'($urandom % 16);
         case (sel)
            0, 1: begin
               wr_addr = 32'h100;
               wr_data = {$urandom % 32'h8000_0000, 1'b0} | {31'd0, ($urandom % 4) != 0};
            end
            2, 3: begin
               wr_addr = 32'h200;
               wr_data = $urandom;
            end
            4, 5: begin
               wr_addr = (sel == 5) ? 32'h5A5A_5300 : 32'h300;
               wr_data = (($urandom % 6) == 0) ? 32'hFFFF_FFFF : $urandom % 24;
            end
            6: begin
               wr_addr = 32'h104;
               wr_data = $urandom;
            end
            default: begin
               wr_addr = {20'($urandom), 12'($urandom)};
               wr_data = $urandom;
            end
         endcase
         @(posedge ACLK); #1;
      end
      wr_en = 1'b0;
      cyc(4);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
      $finish;
   end

endmodule
